// File: rtl/pma_region_table_if.sv
// ---------------------------------------------------------------------------
// pma_region_table_if: config and lookup bus of the PMA region table. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface pma_region_table_if #(
  parameter int AddrWidth = 64,
  parameter int IdxW      = 2
);
  logic                 cfg_req_i;
  logic                 cfg_we_i;
  logic [IdxW-1:0]      cfg_idx_i;
  logic [1:0]           cfg_field_i;
  logic [AddrWidth-1:0] cfg_wdata_i;
  logic                 cfg_gnt_o;
  logic                 cfg_rvalid_o;
  logic [AddrWidth-1:0] cfg_rdata_o;
  logic                 cfg_err_o;

  logic                 lookup_valid_i;
  logic [AddrWidth-1:0] lookup_addr_i;
  logic                 lookup_valid_o;
  logic                 lookup_hit_o;
  logic [IdxW-1:0]      lookup_idx_o;
  logic                 lookup_exec_o;
  logic                 lookup_cached_o;
  logic                 lookup_nonidem_o;

  modport master (
    output cfg_req_i, cfg_we_i, cfg_idx_i, cfg_field_i, cfg_wdata_i,
           lookup_valid_i, lookup_addr_i,
    input  cfg_gnt_o, cfg_rvalid_o, cfg_rdata_o, cfg_err_o,
           lookup_valid_o, lookup_hit_o, lookup_idx_o,
           lookup_exec_o, lookup_cached_o, lookup_nonidem_o
  );

  modport slave (
    input  cfg_req_i, cfg_we_i, cfg_idx_i, cfg_field_i, cfg_wdata_i,
           lookup_valid_i, lookup_addr_i,
    output cfg_gnt_o, cfg_rvalid_o, cfg_rdata_o, cfg_err_o,
           lookup_valid_o, lookup_hit_o, lookup_idx_o,
           lookup_exec_o, lookup_cached_o, lookup_nonidem_o
  );
endinterface

`default_nettype wire

// File: rtl/pma_region_table.sv
// ---------------------------------------------------------------------------
// pma_region_table: programmable base/length PMA rules, 1-cycle lookup. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pma_region_table #(
  parameter int NrRules   = 4,
  parameter int AddrWidth = 64,
  parameter int IdxW      = (NrRules > 1) ? $clog2(NrRules) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  pma_region_table_if.slave bus
);

  localparam logic [1:0] FIELD_BASE = 2'd0;
  localparam logic [1:0] FIELD_LEN  = 2'd1;
  localparam logic [1:0] FIELD_ATTR = 2'd2;
  localparam logic [1:0] FIELD_RSVD = 2'd3;

  logic [AddrWidth-1:0] base_q [NrRules];
  logic [AddrWidth-1:0] len_q  [NrRules];
  logic [3:0]           attr_q [NrRules];

  logic                 idx_ok;
  logic [AddrWidth-1:0] sel_base;
  logic [AddrWidth-1:0] sel_len;
  logic [3:0]           sel_attr;
  logic                 acc_err;
  logic                 cfg_wr;
  logic [AddrWidth-1:0] rd_data;

  logic                 cfg_rvalid_d, cfg_rvalid_q;
  logic [AddrWidth-1:0] cfg_rdata_d, cfg_rdata_q;
  logic                 cfg_err_d, cfg_err_q;

  logic                 lk_hit;
  logic [IdxW-1:0]      lk_idx;
  logic [2:0]           lk_attr;

  logic                 lk_valid_d, lk_valid_q;
  logic                 lk_hit_d, lk_hit_q;
  logic [IdxW-1:0]      lk_idx_d, lk_idx_q;
  logic                 lk_exec_d, lk_exec_q;
  logic                 lk_cached_d, lk_cached_q;
  logic                 lk_nonidem_d, lk_nonidem_q;

  // Index decode doubles as the range check, so no out-of-bounds array access.
  always_comb begin
    idx_ok   = 1'b0;
    sel_base = '0;
    sel_len  = '0;
    sel_attr = '0;
    for (int i = 0; i < NrRules; i++) begin
      if (bus.cfg_idx_i == IdxW'(i)) begin
        idx_ok   = 1'b1;
        sel_base = base_q[i];
        sel_len  = len_q[i];
        sel_attr = attr_q[i];
      end
    end
  end

  always_comb begin
    acc_err = (bus.cfg_field_i == FIELD_RSVD) || !idx_ok ||
              (bus.cfg_we_i && sel_attr[3]);
    cfg_wr  = bus.cfg_req_i && bus.cfg_we_i && !acc_err;
    case (bus.cfg_field_i)
      FIELD_BASE: rd_data = sel_base;
      FIELD_LEN:  rd_data = sel_len;
      FIELD_ATTR: rd_data = AddrWidth'(sel_attr);
      default:    rd_data = '0;
    endcase
  end

  always_comb begin
    cfg_rvalid_d = bus.cfg_req_i;
    cfg_err_d    = bus.cfg_req_i && acc_err;
    cfg_rdata_d  = (bus.cfg_req_i && !bus.cfg_we_i && !acc_err) ? rd_data : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NrRules; i++) begin
        base_q[i] <= '0;
        len_q[i]  <= '0;
        attr_q[i] <= '0;
      end
    end else if (cfg_wr) begin
      for (int i = 0; i < NrRules; i++) begin
        if (bus.cfg_idx_i == IdxW'(i)) begin
          case (bus.cfg_field_i)
            FIELD_BASE: base_q[i] <= bus.cfg_wdata_i;
            FIELD_LEN:  len_q[i]  <= bus.cfg_wdata_i;
            FIELD_ATTR: attr_q[i] <= bus.cfg_wdata_i[3:0];
            default:    ;
          endcase
        end
      end
    end
  end

  // Descending scan lets the lowest matching index overwrite the others.
  always_comb begin
    lk_hit  = 1'b0;
    lk_idx  = '0;
    lk_attr = '0;
    for (int i = NrRules - 1; i >= 0; i--) begin
      if ((len_q[i] != '0) && (bus.lookup_addr_i >= base_q[i]) &&
          ({1'b0, bus.lookup_addr_i} < ({1'b0, base_q[i]} + {1'b0, len_q[i]}))) begin
        lk_hit  = 1'b1;
        lk_idx  = IdxW'(i);
        lk_attr = attr_q[i][2:0];
      end
    end
  end

  always_comb begin
    lk_valid_d   = bus.lookup_valid_i;
    lk_hit_d     = bus.lookup_valid_i && lk_hit;
    lk_idx_d     = (bus.lookup_valid_i && lk_hit) ? lk_idx : '0;
    lk_exec_d    = bus.lookup_valid_i && lk_hit && lk_attr[0];
    lk_cached_d  = bus.lookup_valid_i && lk_hit && lk_attr[1];
    lk_nonidem_d = bus.lookup_valid_i && (lk_hit ? lk_attr[2] : 1'b1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_rvalid_q <= 1'b0;
      cfg_rdata_q  <= '0;
      cfg_err_q    <= 1'b0;
      lk_valid_q   <= 1'b0;
      lk_hit_q     <= 1'b0;
      lk_idx_q     <= '0;
      lk_exec_q    <= 1'b0;
      lk_cached_q  <= 1'b0;
      lk_nonidem_q <= 1'b0;
    end else begin
      cfg_rvalid_q <= cfg_rvalid_d;
      cfg_rdata_q  <= cfg_rdata_d;
      cfg_err_q    <= cfg_err_d;
      lk_valid_q   <= lk_valid_d;
      lk_hit_q     <= lk_hit_d;
      lk_idx_q     <= lk_idx_d;
      lk_exec_q    <= lk_exec_d;
      lk_cached_q  <= lk_cached_d;
      lk_nonidem_q <= lk_nonidem_d;
    end
  end

  assign bus.cfg_gnt_o        = bus.cfg_req_i;
  assign bus.cfg_rvalid_o     = cfg_rvalid_q;
  assign bus.cfg_rdata_o      = cfg_rdata_q;
  assign bus.cfg_err_o        = cfg_err_q;
  assign bus.lookup_valid_o   = lk_valid_q;
  assign bus.lookup_hit_o     = lk_hit_q;
  assign bus.lookup_idx_o     = lk_idx_q;
  assign bus.lookup_exec_o    = lk_exec_q;
  assign bus.lookup_cached_o  = lk_cached_q;
  assign bus.lookup_nonidem_o = lk_nonidem_q;

endmodule

`default_nettype wire

// File: tb/tb_pma_region_table.sv
// ---------------------------------------------------------------------------
// tb_pma_region_table: directed self-checking bench for pma_region_table. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pma_region_table;

  localparam logic [63:0] TOP_BASE = 64'hFFFF_FFFF_FFFF_FFF0;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  pma_region_table_if #(.AddrWidth(64), .IdxW(2)) b ();

  pma_region_table #(
    .NrRules  (4),
    .AddrWidth(64),
    .IdxW     (2)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] lk_out();
    return 64'({b.lookup_valid_o, b.lookup_hit_o, b.lookup_idx_o,
                b.lookup_exec_o, b.lookup_cached_o, b.lookup_nonidem_o});
  endfunction

  function automatic logic [63:0] lk_exp(input logic h, input logic [1:0] ix,
                                         input logic ex, input logic ca, input logic ni);
    return 64'({1'b1, h, ix, ex, ca, ni});
  endfunction

  task automatic cfg(input string tag, input logic we, input logic [1:0] idx,
                     input logic [1:0] fld, input logic [63:0] wd,
                     input logic exp_err, input logic [63:0] exp_rd);
    b.cfg_req_i   = 1'b1;
    b.cfg_we_i    = we;
    b.cfg_idx_i   = idx;
    b.cfg_field_i = fld;
    b.cfg_wdata_i = wd;
    #1;
    chk({tag, "_gnt"}, 64'(b.cfg_gnt_o), 64'd1);
    tick();
    b.cfg_req_i = 1'b0;
    b.cfg_we_i  = 1'b0;
    chk({tag, "_rsp"}, 64'({b.cfg_rvalid_o, b.cfg_err_o}), 64'({1'b1, exp_err}));
    chk({tag, "_rdata"}, b.cfg_rdata_o, exp_rd);
  endtask

  task automatic lk(input string tag, input logic [63:0] a, input logic [63:0] exp);
    b.lookup_valid_i = 1'b1;
    b.lookup_addr_i  = a;
    tick();
    b.lookup_valid_i = 1'b0;
    chk(tag, lk_out(), exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] a;
    logic [63:0] e;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    b.cfg_req_i = 1'b0; b.cfg_we_i = 1'b0; b.cfg_idx_i = '0;
    b.cfg_field_i = '0; b.cfg_wdata_i = '0;
    b.lookup_valid_i = 1'b0; b.lookup_addr_i = '0;

    #3;
    chk("rst_outs", lk_out() | 64'({b.cfg_rvalid_o, b.cfg_err_o}) << 8, 64'd0);
    chk("rst_rdata", b.cfg_rdata_o, 64'd0);
    chk("idle_gnt", 64'(b.cfg_gnt_o), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Single region with exclusive end bound
    cfg("w_r0b", 1, 0, 0, 64'h8000_0000, 0, 0);
    cfg("w_r0l", 1, 0, 1, 64'h4000_0000, 0, 0);
    cfg("w_r0a", 1, 0, 2, 64'hFFFF_FFF3, 0, 0);
    cfg("r_r0b", 0, 0, 0, 0, 0, 64'h8000_0000);
    cfg("r_r0a", 0, 0, 2, 0, 0, 64'h3);
    lk("lk_last", 64'hBFFF_FFFF, lk_exp(1, 0, 1, 1, 0));
    lk("lk_end",  64'hC000_0000, lk_exp(0, 0, 0, 0, 1));
    lk("lk_base", 64'h8000_0000, lk_exp(1, 0, 1, 1, 0));
    lk("lk_below", 64'h7FFF_FFFF, lk_exp(0, 0, 0, 0, 1));

    // Overlapping rules: lowest index wins
    cfg("w_r1b", 1, 1, 0, 64'h0, 0, 0);
    cfg("w_r1l", 1, 1, 1, 64'h1000_0000, 0, 0);
    cfg("w_r1a", 1, 1, 2, 64'h4, 0, 0);
    cfg("w_r2b", 1, 2, 0, 64'h0, 0, 0);
    cfg("w_r2l", 1, 2, 1, 64'h1_0000, 0, 0);
    cfg("w_r2a", 1, 2, 2, 64'h1, 0, 0);
    lk("lk_prio", 64'h100, lk_exp(1, 1, 0, 0, 1));
    lk("lk_r1end", 64'h1000_0000, lk_exp(0, 0, 0, 0, 1));

    // Locking
    cfg("w_r3a", 1, 3, 2, 64'h9, 0, 0);
    cfg("w_lock_b", 1, 3, 0, 64'h1234, 1, 0);
    cfg("r_lock_b", 0, 3, 0, 0, 0, 0);
    cfg("w_lock_a", 1, 3, 2, 64'h0, 1, 0);
    cfg("r_lock_a", 0, 3, 2, 0, 0, 64'h9);
    cfg("r_rsvd", 0, 0, 3, 0, 1, 0);
    cfg("w_rsvd", 1, 1, 3, 64'h55, 1, 0);
    cfg("r_r1l_kept", 0, 1, 1, 0, 0, 64'h1000_0000);

    // Lookup sees table state from before a same-cycle write
    cfg("w_r1l0", 1, 1, 1, 0, 0, 0);
    cfg("w_r2l0", 1, 2, 1, 0, 0, 0);
    cfg("w_r0b0", 1, 0, 0, 0, 0, 0);
    cfg("w_r0l0", 1, 0, 1, 0, 0, 0);
    b.cfg_req_i = 1'b1; b.cfg_we_i = 1'b1; b.cfg_idx_i = 2'd0;
    b.cfg_field_i = 2'd1; b.cfg_wdata_i = 64'h100;
    b.lookup_valid_i = 1'b1; b.lookup_addr_i = 64'h10;
    tick();
    b.cfg_req_i = 1'b0; b.cfg_we_i = 1'b0; b.lookup_valid_i = 1'b0;
    chk("same_cyc_rsp", 64'({b.cfg_rvalid_o, b.cfg_err_o}), 64'b10);
    chk("same_cyc_lk", lk_out(), lk_exp(0, 0, 0, 0, 1));
    lk("lk_after_wr", 64'h10, lk_exp(1, 0, 1, 1, 0));

    // Region ending exactly at the top of the address space
    cfg("w_top_b", 1, 1, 0, TOP_BASE, 0, 0);
    cfg("w_top_l", 1, 1, 1, 64'h10, 0, 0);
    lk("lk_max", 64'hFFFF_FFFF_FFFF_FFFF, lk_exp(1, 1, 0, 0, 1));
    lk("lk_under_top", 64'hFFFF_FFFF_FFFF_FFEF, lk_exp(0, 0, 0, 0, 1));

    // Back-to-back stream of 16 lookups
    for (int i = 0; i < 16; i++) begin
      case (i % 3)
        0:       begin a = 64'(i * 16);   e = lk_exp(1, 0, 1, 1, 0); end
        1:       begin a = TOP_BASE + 64'(i); e = lk_exp(1, 1, 0, 0, 1); end
        default: begin a = 64'h5000 + 64'(i); e = lk_exp(0, 0, 0, 0, 1); end
      endcase
      b.lookup_valid_i = 1'b1;
      b.lookup_addr_i  = a;
      tick();
      chk($sformatf("b2b_%0d", i), lk_out(), e);
    end
    b.lookup_valid_i = 1'b0;
    tick();
    chk("lk_idle_zero", lk_out(), 64'd0);

    // Reset in the middle of a pending access and lookup
    b.cfg_req_i = 1'b1; b.cfg_we_i = 1'b0; b.cfg_idx_i = 2'd3; b.cfg_field_i = 2'd2;
    b.lookup_valid_i = 1'b1; b.lookup_addr_i = 64'h10;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", lk_out() | 64'({b.cfg_rvalid_o, b.cfg_err_o}) << 8, 64'd0);
    chk("mid_rst_rdata", b.cfg_rdata_o, 64'd0);
    tick();
    b.cfg_req_i = 1'b0; b.lookup_valid_i = 1'b0;
    chk("in_rst_outs", lk_out() | 64'({b.cfg_rvalid_o, b.cfg_err_o}) << 8, 64'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_outs", lk_out() | 64'({b.cfg_rvalid_o, b.cfg_err_o}) << 8, 64'd0);
    cfg("r_lock_clr", 0, 3, 2, 0, 0, 0);
    cfg("w_after_rst", 1, 3, 0, 64'h55, 0, 0);
    lk("lk_after_rst", 64'h10, lk_exp(0, 0, 0, 0, 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pma_region_table.md
PMA_REGION_TABLE -- requirements
Module: pma_region_table

Interface
REQ-001 Parameter NrRules, default 4: number of runtime-programmable address rules, legal range 1..16.
REQ-002 Parameter AddrWidth, default 64: width of physical addresses, base and length registers.
REQ-003 Parameter IdxW, default max(1, clog2(NrRules)): width of rule index ports.
REQ-004 clk_i  in  1  single clock, all state on rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 cfg_req_i  in  1  config access request.
REQ-007 cfg_we_i  in  1  1=write, 0=read.
REQ-008 cfg_idx_i  in  IdxW  target rule.
REQ-009 cfg_field_i  in  2  0=base, 1=length, 2=attr, 3=reserved.
REQ-010 cfg_wdata_i  in  AddrWidth  write data; attr field uses bits[3:0] = {lock, nonidem, cached, exec}.
REQ-011 cfg_gnt_o  out  1  request accepted.
REQ-012 cfg_rvalid_o  out  1  response valid.
REQ-013 cfg_rdata_o  out  AddrWidth  read data.
REQ-014 cfg_err_o  out  1  access error.
REQ-015 lookup_valid_i  in  1  lookup request.
REQ-016 lookup_addr_i  in  AddrWidth  address to classify.
REQ-017 lookup_valid_o  out  1  lookup result valid.
REQ-018 lookup_hit_o  out  1  some rule matched.
REQ-019 lookup_idx_o  out  IdxW  matching rule index.
REQ-020 lookup_exec_o / lookup_cached_o / lookup_nonidem_o  out  1 each  region attributes.

Function
REQ-021 cfg_gnt_o SHALL equal cfg_req_i combinationally (every request accepted in its cycle).
REQ-022 Accepted access SHALL produce cfg_rvalid_o=1 exactly one cycle later, for one cycle; cfg_rdata_o/cfg_err_o valid only then, else 0.
REQ-023 Read: cfg_rdata_o = selected field, attr zero-extended from 4 bits; write response cfg_rdata_o=0.
REQ-024 Write to unlocked rule SHALL update the field at the accepting clock edge; attr write stores bits[3:0] only.
REQ-025 cfg_err_o=1 and no state change for: field 3, cfg_idx_i >= NrRules, write to rule whose lock bit is 1.
REQ-026 Lock bit, once 1, SHALL stay 1 until reset; locked rule readable without error.
REQ-027 Rule i matches when length_i != 0 and base_i <= addr < base_i + length_i, sum computed in AddrWidth+1 bits (no wrap-around; region ending at 2^AddrWidth legal).
REQ-028 Lowest-index matching rule SHALL win.
REQ-029 Lookup latency exactly 1 cycle: lookup_valid_o(N+1)=lookup_valid_i(N); one lookup per cycle, fully pipelined, no backpressure.
REQ-030 Lookup accepted in cycle N SHALL use table contents before any write accepted in cycle N.
REQ-031 Hit: lookup_hit_o=1, idx/attr of winning rule; miss: hit=0, idx=0, exec=0, cached=0, nonidem=1.
REQ-032 When lookup_valid_o=0 all lookup_* outputs SHALL be 0.
REQ-033 Result registers SHALL hold only when lookup_valid_i=0 clears them; no stale result presented as valid.

Reset
REQ-034 On rst_ni=0, immediately: all base, length, attr (incl. lock) = 0; cfg_rvalid_o, cfg_rdata_o, cfg_err_o, all lookup_* outputs = 0.
REQ-035 Reset asserted mid-access or mid-lookup SHALL discard the pending response; first response after release only for a request accepted after release.

Verification
REQ-036 Write rule0 base=0x8000_0000, length=0x4000_0000, attr=0x3; lookup 0xBFFF_FFFF -> next cycle hit=1, idx=0, exec=1, cached=1, nonidem=0; lookup 0xC000_0000 -> hit=0, nonidem=1.
REQ-037 Rule1 base=0x0, length=0x1000_0000, attr=0x4; rule2 base=0x0, length=0x1_0000, attr=0x1; lookup 0x100 -> idx=1, nonidem=1, exec=0 (priority).
REQ-038 Rule3 attr=0x9 (lock+exec), then write base=0x1234 -> cfg_err_o=1, read base returns 0; write attr=0x0 -> err=1, attr still 0x9.
REQ-039 Same-cycle write rule0 length 0->0x100 (base 0) and lookup 0x10 -> miss; lookup next cycle -> hit idx=0.
REQ-040 Back-to-back lookups every cycle for 16 cycles -> 16 consecutive valid results in order; read field=3 -> err=1; rule base=2^AddrWidth-0x10, length=0x10, lookup all-ones -> hit; assert rst_ni mid-stream -> all outputs 0, lock cleared.
